hazard_ctrl: RTL and testbench

//  Decode-stage hazard controller for the 5-stage pipeline. Tracks the destination of the

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: EX/MEM/WB destination tracking, bypass selects, load-use stalls.
// Optional perf counters (lu_cnt, fwd_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int ADDR_SIZE = 5
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic                 D_use_ra,
    input  logic                 D_use_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_we,
    input  logic                 D_ld,
    input  logic                 flush,
    input  logic                 mem_stall,
    output logic [1:0]           EX_D_bp,
    output logic [1:0]           MEM_D_bp,
    output logic [1:0]           WB_D_bp,
    output logic                 D_stall,
    output logic                 EX_bubble
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     lu_cnt,
    output logic [CNT_W-1:0]     fwd_cnt
`endif
);

    typedef struct packed {
        logic                 v;
        logic                 we;
        logic                 ld;
        logic [ADDR_SIZE-1:0] rd;
    } stage_t;

    typedef enum logic [1:0] {RUN, LU, HOLD} state_t;

    stage_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_t state_q, state_d;

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic lu_raw, lu;

    function automatic logic hit(input stage_t s, input logic [ADDR_SIZE-1:0] r);
        return s.v & s.we & (s.rd == r) & (r != '0);
    endfunction

    always_comb begin
        ex_hit_a  = D_use_ra & hit(ex_q,  D_ra);
        ex_hit_b  = D_use_rb & hit(ex_q,  D_rb);
        mem_hit_a = D_use_ra & hit(mem_q, D_ra);
        mem_hit_b = D_use_rb & hit(mem_q, D_rb);
        wb_hit_a  = D_use_ra & hit(wb_q,  D_ra);
        wb_hit_b  = D_use_rb & hit(wb_q,  D_rb);

        // A load in EX still claims the operand, masking older MEM/WB matches.
        EX_D_bp  = {ex_hit_a & ~ex_q.ld, ex_hit_b & ~ex_q.ld};
        MEM_D_bp = {mem_hit_a & ~ex_hit_a, mem_hit_b & ~ex_hit_b};
        WB_D_bp  = {wb_hit_a & ~ex_hit_a & ~mem_hit_a, wb_hit_b & ~ex_hit_b & ~mem_hit_b};

        // In LU the load has already moved to MEM, so a repeat stall is never legitimate.
        lu_raw    = D_valid & ex_q.ld & (ex_hit_a | ex_hit_b) & (state_q != LU);
        lu        = lu_raw & ~flush;
        D_stall   = mem_stall | lu;
        EX_bubble = ~mem_stall & lu_raw;
    end

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        state_d = state_q;
        if (!mem_stall) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = '0;
            if (D_valid && !D_stall && !flush) begin
                ex_d.v  = 1'b1;
                ex_d.we = D_we;
                ex_d.ld = D_ld;
                ex_d.rd = D_rd;
            end
        end
        unique case (state_q)
            RUN:     state_d = mem_stall ? HOLD : (lu ? LU : RUN);
            LU:      state_d = mem_stall ? HOLD : RUN;
            HOLD:    state_d = mem_stall ? HOLD : (lu ? LU : RUN);
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        fwd_cnt_d = fwd_cnt_q;
        if (lu && !mem_stall)
            lu_cnt_d = lu_cnt_q + 1'b1;
        if (|{EX_D_bp, MEM_D_bp, WB_D_bp})
            fwd_cnt_d = fwd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q  <= '0;
            fwd_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            fwd_cnt_q <= fwd_cnt_d;
        end
    end

    assign lu_cnt  = lu_cnt_q;
    assign fwd_cnt = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed decode vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       D_valid, D_use_ra, D_use_rb, D_we, D_ld, flush, mem_stall;
    logic [4:0] D_ra, D_rb, D_rd;
    logic [1:0] EX_D_bp, MEM_D_bp, WB_D_bp;
    logic       D_stall, EX_bubble;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt, fwd_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D_valid   (D_valid),
        .D_ra      (D_ra),
        .D_rb      (D_rb),
        .D_use_ra  (D_use_ra),
        .D_use_rb  (D_use_rb),
        .D_rd      (D_rd),
        .D_we      (D_we),
        .D_ld      (D_ld),
        .flush     (flush),
        .mem_stall (mem_stall),
        .EX_D_bp   (EX_D_bp),
        .MEM_D_bp  (MEM_D_bp),
        .WB_D_bp   (WB_D_bp),
        .D_stall   (D_stall),
        .EX_bubble (EX_bubble)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .lu_cnt    (lu_cnt),
        .fwd_cnt   (fwd_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic [7:0] exp;   // {EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, EX_bubble}
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Monitor: the DUT outputs are combinational, so every pushed vector is observable mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] got;
            e   = sb.pop_front();
            got = {EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, EX_bubble};
            n_vec++;
            if (got !== e.exp) begin
                n_miss++;
                $display("FAIL %s: got ex=%b mem=%b wb=%b stall=%b bubble=%b, required ex=%b mem=%b wb=%b stall=%b bubble=%b",
                         e.name, got[7:6], got[5:4], got[3:2], got[1], got[0],
                         e.exp[7:6], e.exp[5:4], e.exp[3:2], e.exp[1], e.exp[0]);
            end else begin
                $display("vec %-14s ex=%b mem=%b wb=%b stall=%b bubble=%b", e.name,
                         got[7:6], got[5:4], got[3:2], got[1], got[0]);
            end
        end
    end

    task automatic step(input string nm, input int rn, input int v, input int ra, input int rb,
                        input int ua, input int ub, input int rd, input int we, input int ld,
                        input int fl, input int ms, input logic [7:0] e);
        exp_t x;
        rst_n     = rn[0];
        D_valid   = v[0];
        D_ra      = ra[4:0];
        D_rb      = rb[4:0];
        D_use_ra  = ua[0];
        D_use_rb  = ub[0];
        D_rd      = rd[4:0];
        D_we      = we[0];
        D_ld      = ld[0];
        flush     = fl[0];
        mem_stall = ms[0];
        x.name = nm;
        x.exp  = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {D_valid, D_use_ra, D_use_rb, D_we, D_ld, flush, mem_stall} = '0;
        {D_ra, D_rb, D_rd} = '0;
        @(posedge clk);
        #1;
        //    name            rn v  ra  rb ua ub rd we ld fl ms  ex_mem_wb_s_b
        step("reset",         0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 8'b00_00_00_0_0);
        step("add_x5",        1, 1,  1,  2, 1, 1, 5, 1, 0, 0, 0, 8'b00_00_00_0_0);
        step("raw_ex_x5",     1, 1,  5,  5, 1, 1, 6, 1, 0, 0, 0, 8'b11_00_00_0_0);
        step("lw_x7",         1, 1,  1,  0, 1, 0, 7, 1, 1, 0, 0, 8'b00_00_00_0_0);
        step("lu_stall",      1, 1,  7,  1, 1, 1, 8, 1, 0, 0, 0, 8'b00_00_00_1_1);
        step("lu_mem_fwd",    1, 1,  7,  1, 1, 1, 8, 1, 0, 0, 0, 8'b00_10_00_0_0);
        step("add_x3",        1, 1,  0,  0, 0, 0, 3, 1, 0, 0, 0, 8'b00_00_00_0_0);
        step("nop_a",         1, 1,  0,  0, 0, 0, 0, 0, 0, 0, 0, 8'b00_00_00_0_0);
        step("nop_b",         1, 1,  0,  0, 0, 0, 0, 0, 0, 0, 0, 8'b00_00_00_0_0);
        step("wb_fwd_rb_x3",  1, 1,  2,  3, 1, 1, 9, 1, 0, 0, 0, 8'b00_00_01_0_0);
        step("add_x0",        1, 1,  0,  0, 0, 0, 0, 1, 0, 0, 0, 8'b00_00_00_0_0);
        step("read_x0_a",     1, 1,  0,  0, 1, 1, 0, 1, 0, 0, 0, 8'b00_00_00_0_0);
        step("read_x0_b",     1, 1,  0,  0, 1, 1, 0, 1, 0, 0, 0, 8'b00_00_00_0_0);
        step("add_x10",       1, 1,  0,  0, 0, 0,10, 1, 0, 0, 0, 8'b00_00_00_0_0);
        for (int k = 0; k < 4; k++)
            step($sformatf("mstall_%0d", k),
                              1, 1, 10, 10, 1, 1,11, 1, 0, 0, 1, 8'b11_00_00_1_0);
        step("mstall_release",1, 1, 10, 10, 1, 1,11, 1, 0, 0, 0, 8'b11_00_00_0_0);
        step("lw_x12",        1, 1,  0,  0, 0, 0,12, 1, 1, 0, 0, 8'b00_00_00_0_0);
        step("flush_lu",      1, 1, 12,  0, 1, 0,13, 1, 0, 1, 0, 8'b00_00_00_0_1);
        step("after_flush",   1, 1, 12,  0, 1, 0, 0, 0, 0, 0, 0, 8'b00_10_00_0_0);
        step("lw_x14_a",      1, 1,  0,  0, 0, 0,14, 1, 1, 0, 0, 8'b00_00_00_0_0);
        step("lw_x14_b",      1, 1,  0,  0, 0, 0,14, 1, 1, 0, 0, 8'b00_00_00_0_0);
        step("use_x14_lu",    1, 1,  0, 14, 0, 1,15, 0, 0, 0, 0, 8'b00_00_00_1_1);
        step("use_x14_young", 1, 1,  0, 14, 0, 1,15, 0, 0, 0, 0, 8'b00_01_00_0_0);
        step("lw_x16",        1, 1,  0,  0, 0, 0,16, 1, 1, 0, 0, 8'b00_00_00_0_0);
        step("lu_in_mstall",  1, 1, 16,  0, 1, 0,17, 1, 0, 0, 1, 8'b00_00_00_1_0);
        step("reset_mid",     0, 1, 16,  0, 1, 0,17, 1, 0, 0, 0, 8'b00_00_00_0_0);
        for (int k = 0; k < 3; k++)
            step($sformatf("post_rst_%0d", k),
                              1, 1, 16,  5, 1, 1, 0, 0, 0, 0, 0, 8'b00_00_00_0_0);

        D_valid = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(posedge clk);
        if (sb.size() > 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending vectors, required 0", sb.size());
        end
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        n_vec++;
        if (lu_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin
            n_miss++;
            $display("FAIL perf_after_reset: got lu_cnt=%0d fwd_cnt=%0d, required 0 and 0", lu_cnt, fwd_cnt);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
